// File: rtl/worker_stream.sv
// Per-vertex neighbor scoring worker: accumulates partition hit counts over sub-batch beats,
// picks the argmax partition, packs Q decisions per batch and keeps a proposal histogram.
// Build option: define WORKER_SAT_EN to saturate per-partition scores instead of wrapping.
module worker_stream #(
   parameter int K       = 16,
   parameter int D       = 256,
   parameter int LOC_BW  = 5,
   parameter int Q       = 16,
   parameter int VID_BW  = 16,
   parameter int CNT_BW  = 12,
   parameter int PRO_BW  = 8,
   parameter int ADDR_BW = 4,
   parameter int NEXT_BW = $clog2(K)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [7:0]              batch_num,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [VID_BW-1:0]       in_vid,
   input  logic [D-1:0]            in_dist,
   input  logic [D*LOC_BW-1:0]     in_loc,
   input  logic                    in_last,
   output logic                    res_valid,
   output logic [VID_BW-1:0]       res_vid,
   output logic [NEXT_BW-1:0]      res_next,
   output logic [CNT_BW-1:0]       res_score,
   output logic                    next_we,
   output logic [ADDR_BW-1:0]      next_waddr,
   output logic [Q*NEXT_BW-1:0]    next_wdata,
   output logic                    pro_we,
   output logic [ADDR_BW-1:0]      pro_waddr,
   output logic [K*PRO_BW-1:0]     pro_wdata,
   output logic                    batch_finish
);
   // state | meaning
   // ACC   | accepting sub-batch beats of the current vertex
   // ARG   | argmax over partition scores, registered on exit
   // EMIT  | result pulses visible; clears scores on exit
   localparam logic [1:0] S_ACC  = 2'd0;
   localparam logic [1:0] S_ARG  = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;

   localparam int CW = $clog2(D + 1);
   localparam int QW = (Q > 1) ? $clog2(Q) : 1;

   logic [1:0]          state;
   logic [CNT_BW-1:0]   part   [K];
   logic [CNT_BW-1:0]   part_n [K];
   logic [CNT_BW:0]     sum    [K];
   logic [CW-1:0]       cnt    [K];
   logic [PRO_BW-1:0]   hist   [K];
   logic [PRO_BW-1:0]   hist_n [K];
   logic [QW-1:0]       q;
   logic                mid_vertex;
   logic [VID_BW-1:0]   vid_r;
   logic [ADDR_BW-1:0]  waddr_r;
   logic [NEXT_BW-1:0]  best_idx;
   logic [CNT_BW-1:0]   best_val;
   logic                accept;
   logic                last_slot;
   logic                unused_batch_bits;

   assign in_ready   = (state == S_ACC);
   assign accept     = in_valid && in_ready;
   assign last_slot  = (q == QW'(Q - 1));
   assign next_waddr = waddr_r;
   assign pro_waddr  = waddr_r;
   assign unused_batch_bits = ^batch_num;

   // Unassigned neighbors (location MSB set) never contribute to a score.
   always_comb begin
      for (int k = 0; k < K; k++) cnt[k] = '0;
      for (int i = 0; i < D; i++) begin
         if (in_dist[i] && !in_loc[i*LOC_BW + LOC_BW - 1])
            cnt[in_loc[i*LOC_BW +: NEXT_BW]] = cnt[in_loc[i*LOC_BW +: NEXT_BW]] + CW'(1);
      end
   end

   always_comb begin
      for (int k = 0; k < K; k++) begin
         sum[k] = {1'b0, part[k]} + (CNT_BW+1)'(cnt[k]);
`ifdef WORKER_SAT_EN
         part_n[k] = sum[k][CNT_BW] ? {CNT_BW{1'b1}} : sum[k][CNT_BW-1:0];
`else
         part_n[k] = sum[k][CNT_BW-1:0];
`endif
      end
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_idx = '0;
      best_val = part[0];
      for (int k = 1; k < K; k++) begin
         if (part[k] > best_val) begin
            best_idx = NEXT_BW'(k);
            best_val = part[k];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < K; k++) hist_n[k] = hist[k];
      if (hist[best_idx] != {PRO_BW{1'b1}})
         hist_n[best_idx] = hist[best_idx] + PRO_BW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_ACC;
         q            <= '0;
         mid_vertex   <= 1'b0;
         vid_r        <= '0;
         waddr_r      <= '0;
         res_valid    <= 1'b0;
         res_vid      <= '0;
         res_next     <= '0;
         res_score    <= '0;
         next_we      <= 1'b0;
         pro_we       <= 1'b0;
         batch_finish <= 1'b0;
         next_wdata   <= '0;
         pro_wdata    <= '0;
         for (int k = 0; k < K; k++) begin
            part[k] <= '0;
            hist[k] <= '0;
         end
      end else if (flush) begin
         state        <= S_ACC;
         q            <= '0;
         mid_vertex   <= 1'b0;
         res_valid    <= 1'b0;
         next_we      <= 1'b0;
         pro_we       <= 1'b0;
         batch_finish <= 1'b0;
         for (int k = 0; k < K; k++) begin
            part[k] <= '0;
            hist[k] <= '0;
         end
      end else begin
         case (state)
            S_ACC: begin
               if (accept) begin
                  for (int k = 0; k < K; k++) part[k] <= part_n[k];
                  if (!mid_vertex) begin
                     vid_r <= in_vid;
                     if (q == '0) waddr_r <= batch_num[ADDR_BW-1:0];
                  end
                  if (in_last) begin
                     state      <= S_ARG;
                     mid_vertex <= 1'b0;
                  end else begin
                     mid_vertex <= 1'b1;
                  end
               end
            end
            S_ARG: begin
               res_valid <= 1'b1;
               res_vid   <= vid_r;
               res_next  <= best_idx;
               res_score <= best_val;
               next_wdata[int'(q)*NEXT_BW +: NEXT_BW] <= best_idx;
               for (int k = 0; k < K; k++) hist[k] <= hist_n[k];
               if (last_slot) begin
                  next_we      <= 1'b1;
                  pro_we       <= 1'b1;
                  batch_finish <= 1'b1;
                  for (int k = 0; k < K; k++) pro_wdata[k*PRO_BW +: PRO_BW] <= hist_n[k];
               end
               state <= S_EMIT;
            end
            S_EMIT: begin
               res_valid    <= 1'b0;
               next_we      <= 1'b0;
               pro_we       <= 1'b0;
               batch_finish <= 1'b0;
               for (int k = 0; k < K; k++) part[k] <= '0;
               if (last_slot) begin
                  q <= '0;
                  for (int k = 0; k < K; k++) hist[k] <= '0;
               end else begin
                  q <= q + QW'(1);
               end
               state <= S_ACC;
            end
            default: state <= S_ACC;
         endcase
      end
   end
endmodule

// File: tb/tb_worker_stream.sv
// Directed bench for worker_stream: scoring, argmax ties, batch packing, flush, wrap/saturate
// (follows WORKER_SAT_EN) and asynchronous reset.
module tb_worker_stream;
   localparam int K = 16, D = 256, LOC_BW = 5, Q = 16, VID_BW = 16;
   localparam int CNT_BW = 12, PRO_BW = 8, ADDR_BW = 4, NB = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 flush = 1'b0;
   logic [7:0]           batch_num = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [VID_BW-1:0]    in_vid = '0;
   logic [D-1:0]         in_dist = '0;
   logic [D*LOC_BW-1:0]  in_loc = '0;
   logic                 in_last = 1'b0;
   logic                 res_valid;
   logic [VID_BW-1:0]    res_vid;
   logic [NB-1:0]        res_next;
   logic [CNT_BW-1:0]    res_score;
   logic                 next_we;
   logic [ADDR_BW-1:0]   next_waddr;
   logic [Q*NB-1:0]      next_wdata;
   logic                 pro_we;
   logic [ADDR_BW-1:0]   pro_waddr;
   logic [K*PRO_BW-1:0]  pro_wdata;
   logic                 batch_finish;

   int total = 0;
   int bad = 0;
   logic [D-1:0]         dist_v;
   logic [D*LOC_BW-1:0]  loc_v;

   worker_stream dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .batch_num(batch_num),
      .in_valid(in_valid), .in_ready(in_ready), .in_vid(in_vid), .in_dist(in_dist),
      .in_loc(in_loc), .in_last(in_last), .res_valid(res_valid), .res_vid(res_vid),
      .res_next(res_next), .res_score(res_score), .next_we(next_we),
      .next_waddr(next_waddr), .next_wdata(next_wdata), .pro_we(pro_we),
      .pro_waddr(pro_waddr), .pro_wdata(pro_wdata), .batch_finish(batch_finish)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_beat();
      dist_v = '0;
      loc_v  = '0;
   endtask

   task automatic add_hits(input int start, input int n, input logic [4:0] l);
      for (int i = start; i < start + n; i++) begin
         dist_v[i] = 1'b1;
         loc_v[i*LOC_BW +: LOC_BW] = l;
      end
   endtask

   task automatic send_beat(input logic [15:0] vid, input logic last, input logic [7:0] bn);
      in_dist = dist_v; in_loc = loc_v; in_vid = vid; in_last = last; batch_num = bn;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({res_valid, res_vid, res_next, res_score, next_we, pro_we, batch_finish} !== '0 ||
          next_waddr !== '0 || pro_waddr !== '0 || next_wdata !== '0 || pro_wdata !== '0) begin
         bad++; $display("FAIL reset_outputs: some output nonzero res_vid=%h next_wdata=%h", res_vid, next_wdata);
      end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b need 1", in_ready); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_beat();
      clr_beat();
      for (int i = 0; i < D; i++) begin
         dist_v[i] = 1'b1;
         loc_v[i*LOC_BW +: LOC_BW] = 5'(i % 16);
      end
      send_beat(16'h0042, 1'b1, 8'h00);
      total++;
      if (in_ready !== 1'b0 || res_valid !== 1'b0) begin
         bad++; $display("FAIL single_arg: in_ready=%b res_valid=%b need 0 0", in_ready, res_valid);
      end
      tick();
      total++;
      if (in_ready !== 1'b0 || res_valid !== 1'b1) begin
         bad++; $display("FAIL single_emit: in_ready=%b res_valid=%b need 0 1", in_ready, res_valid);
      end
      total++;
      if (res_vid !== 16'h0042 || res_next !== 4'd0 || res_score !== 12'd16) begin
         bad++; $display("FAIL single_result: vid=%h next=%0d score=%0d need 0042 0 16", res_vid, res_next, res_score);
      end
      tick();
      total++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
         bad++; $display("FAIL single_after: in_ready=%b res_valid=%b need 1 0", in_ready, res_valid);
      end
   endtask

   task automatic test_multi_beat();
      clr_beat();
      add_hits(0, 10, 5'd7);
      send_beat(16'h0100, 1'b0, 8'h00);
      total++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
         bad++; $display("FAIL multi_mid: in_ready=%b res_valid=%b need 1 0", in_ready, res_valid);
      end
      clr_beat();
      add_hits(0, 5, 5'd2);
      add_hits(5, 3, 5'd7);
      add_hits(8, 200, 5'h12);
      send_beat(16'h0200, 1'b1, 8'h00);
      tick();
      total++;
      if (res_valid !== 1'b1 || res_vid !== 16'h0100 || res_next !== 4'd7 || res_score !== 12'd13) begin
         bad++; $display("FAIL multi_result: valid=%b vid=%h next=%0d score=%0d need 1 0100 7 13",
                         res_valid, res_vid, res_next, res_score);
      end
      tick();
   endtask

   task automatic test_batch_write();
      logic [Q*NB-1:0]     exp_next;
      logic [K*PRO_BW-1:0] exp_pro;
      logic                wr;
      pulse_flush();
      exp_next = '0;
      exp_pro  = '0;
      for (int v = 0; v < Q; v++) exp_next[v*NB +: NB] = 4'(v % 4);
      for (int k = 0; k < 4; k++) exp_pro[k*PRO_BW +: PRO_BW] = 8'd4;
      for (int v = 0; v < Q; v++) begin
         clr_beat();
         add_hits(0, 3, 5'(v % 4));
         send_beat(16'(16'h0300 + v), 1'b1, (v == 0) ? 8'h25 : 8'h00);
         tick();
         wr = (v == Q - 1);
         total++;
         if (res_valid !== 1'b1 || res_next !== 4'(v % 4) || res_vid !== 16'(16'h0300 + v)) begin
            bad++; $display("FAIL batch_result v=%0d: valid=%b next=%0d vid=%h", v, res_valid, res_next, res_vid);
         end
         total++;
         if (next_we !== wr || pro_we !== wr || batch_finish !== wr) begin
            bad++; $display("FAIL batch_strobe v=%0d: we=%b%b%b need %b", v, next_we, pro_we, batch_finish, wr);
         end
         if (wr) begin
            total++;
            if (next_waddr !== 4'd5 || pro_waddr !== 4'd5) begin
               bad++; $display("FAIL batch_addr: next=%0d pro=%0d need 5", next_waddr, pro_waddr);
            end
            total++;
            if (next_wdata !== exp_next) begin
               bad++; $display("FAIL batch_next: got %h need %h", next_wdata, exp_next);
            end
            total++;
            if (pro_wdata !== exp_pro) begin
               bad++; $display("FAIL batch_pro: got %h need %h", pro_wdata, exp_pro);
            end
         end
         tick();
      end
      total++;
      if (next_we !== 1'b0 || pro_we !== 1'b0 || batch_finish !== 1'b0 || next_wdata !== exp_next) begin
         bad++; $display("FAIL batch_drop: we=%b%b%b next_wdata=%h", next_we, pro_we, batch_finish, next_wdata);
      end
   endtask

   task automatic test_flush();
      logic [Q*NB-1:0]     exp_next;
      logic [K*PRO_BW-1:0] exp_pro;
      logic                wr;
      for (int v = 0; v < 3; v++) begin
         clr_beat();
         add_hits(0, 4, 5'd1);
         send_beat(16'(16'h0400 + v), 1'b1, 8'h00);
         tick();
         tick();
      end
      clr_beat();
      add_hits(0, 10, 5'd5);
      send_beat(16'h04ff, 1'b0, 8'h00);
      pulse_flush();
      for (int c = 0; c < 3; c++) begin
         total++;
         if (res_valid !== 1'b0 || in_ready !== 1'b1 || next_we !== 1'b0) begin
            bad++; $display("FAIL flush_idle c=%0d: valid=%b ready=%b we=%b", c, res_valid, in_ready, next_we);
         end
         tick();
      end
      total++;
      if (res_vid !== 16'h0402 || res_next !== 4'd1 || res_score !== 12'd4) begin
         bad++; $display("FAIL flush_hold: vid=%h next=%0d score=%0d need 0402 1 4", res_vid, res_next, res_score);
      end
      exp_next = '0;
      for (int v = 0; v < Q; v++) exp_next[v*NB +: NB] = 4'd9;
      exp_pro = '0;
      exp_pro[9*PRO_BW +: PRO_BW] = 8'd16;
      for (int v = 0; v < Q; v++) begin
         clr_beat();
         add_hits(0, 2, 5'd9);
         send_beat(16'(16'h0500 + v), 1'b1, (v == 0) ? 8'h3a : 8'h00);
         tick();
         wr = (v == Q - 1);
         total++;
         if (res_valid !== 1'b1 || res_next !== 4'd9 || res_score !== 12'd2) begin
            bad++; $display("FAIL flush_result v=%0d: valid=%b next=%0d score=%0d need 1 9 2", v, res_valid, res_next, res_score);
         end
         total++;
         if (next_we !== wr || pro_we !== wr || batch_finish !== wr) begin
            bad++; $display("FAIL flush_strobe v=%0d: we=%b%b%b need %b", v, next_we, pro_we, batch_finish, wr);
         end
         if (wr) begin
            total++;
            if (next_waddr !== 4'ha || next_wdata !== exp_next || pro_wdata !== exp_pro) begin
               bad++; $display("FAIL flush_batch: addr=%h next=%h pro=%h need a %h %h", next_waddr, next_wdata, pro_wdata, exp_next, exp_pro);
            end
         end
         tick();
      end
   endtask

   task automatic test_wrap_or_sat();
      logic [3:0]  exp_n;
      logic [11:0] exp_s;
`ifdef WORKER_SAT_EN
      exp_n = 4'd3; exp_s = 12'd4095;
`else
      exp_n = 4'd0; exp_s = 12'd0;
`endif
      clr_beat();
      add_hits(0, D, 5'd3);
      for (int b = 0; b < 16; b++)
         send_beat((b == 0) ? 16'h0444 : 16'hffff, (b == 15), 8'h00);
      tick();
      total++;
      if (res_valid !== 1'b1 || res_vid !== 16'h0444 || res_next !== exp_n || res_score !== exp_s) begin
         bad++; $display("FAIL wrap_sat: valid=%b vid=%h next=%0d score=%0d need 1 0444 %0d %0d",
                         res_valid, res_vid, res_next, res_score, exp_n, exp_s);
      end
      tick();
   endtask

   task automatic test_async_reset();
      clr_beat();
      add_hits(0, 20, 5'd4);
      send_beat(16'h0555, 1'b0, 8'h00);
      clr_beat();
      add_hits(0, 5, 5'd6);
      in_dist = dist_v; in_loc = loc_v; in_vid = 16'h0777; in_last = 1'b1; in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({res_valid, res_vid, res_next, res_score, next_we, pro_we, batch_finish} !== '0 ||
          next_wdata !== '0 || pro_wdata !== '0 || next_waddr !== '0) begin
         bad++; $display("FAIL async_outputs: res_vid=%h next_wdata=%h pro_wdata=%h need 0", res_vid, next_wdata, pro_wdata);
      end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL async_ready: got %b need 1", in_ready); end
      tick();
      rst_n = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL async_accept: in_ready=%b need 0", in_ready); end
      tick();
      total++;
      if (res_valid !== 1'b1 || res_vid !== 16'h0777 || res_next !== 4'd6 || res_score !== 12'd5) begin
         bad++; $display("FAIL async_fresh: valid=%b vid=%h next=%0d score=%0d need 1 0777 6 5",
                         res_valid, res_vid, res_next, res_score);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_multi_beat();
      test_batch_write();
      test_flush();
      test_wrap_or_sat();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
